// File: rtl/f2h_status_tx_if.sv
// f2h_status_tx_if: MMIO link bundle between host and the status transmitter.
//  h2f_pio32  host command word, driven by the host (master)
//  h2f_write  host command strobe, one cycle per word
//  f2h_pio32  status snapshot, driven by the transmitter (slave)
//  f2h_write  one-cycle strobe qualifying f2h_pio32
interface f2h_status_tx_if;
    logic [31:0] h2f_pio32;
    logic        h2f_write;
    logic [31:0] f2h_pio32;
    logic        f2h_write;
    modport master (output h2f_pio32, h2f_write, input f2h_pio32, f2h_write);
    modport slave (input h2f_pio32, h2f_write, output f2h_pio32, f2h_write);
endinterface

// File: rtl/f2h_status_tx.sv
// f2h_status_tx: turns level done flags into sticky events and pushes rate-limited status snapshots to the host.
//  clk, rst_n          single clock, asynchronous active-low reset
//  move_done..fetch_done, exec_done[27:0]   level done flags
//  bus (slave)         h2f command snoop (ACK/POLL opcodes only), f2h snapshot word + one-cycle strobe
module f2h_status_tx #(
    parameter int         HOLD_CYCLES = 16,
    parameter logic [3:0] ACK_OPCODE  = 4'hF,
    parameter logic [3:0] POLL_OPCODE = 4'hE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          move_done,
    input  logic          ldst_done,
    input  logic          cu_done,
    input  logic          fetch_done,
    input  logic [27:0]   exec_done,
    f2h_status_tx_if.slave bus
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [31:0]   in_vec;
    logic [31:0]   prev;
    logic [31:0]   sticky;
    logic [31:0]   rise;
    logic [31:0]   next_sticky;
    logic [31:0]   word_q;
    logic          write_q;
    logic          pending;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          ack;
    logic          poll;
    logic          new_evt;
    logic          unused_arg_bits;
    assign in_vec          = {move_done, ldst_done, cu_done, fetch_done, exec_done};
    assign rise            = in_vec & ~prev;
    assign ack             = bus.h2f_write && bus.h2f_pio32[31:28] == ACK_OPCODE;
    assign poll            = bus.h2f_write && bus.h2f_pio32[31:28] == POLL_OPCODE;
    // An edge arriving with ACK survives the clear.
    assign next_sticky     = (ack ? 32'h0 : sticky) | rise;
    // Only bits not already sticky count as news; re-rising a reported bit is silent.
    assign new_evt         = |(rise & ~sticky);
    // Command argument bits are don't-care for ACK and POLL.
    assign unused_arg_bits = ^bus.h2f_pio32[27:0];
    assign bus.f2h_pio32   = word_q;
    assign bus.f2h_write   = write_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            sticky  <= '0;
            word_q  <= '0;
            write_q <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
        end else begin
            prev   <= in_vec;
            sticky <= next_sticky;
            if (state == IDLE) begin
                if (pending) begin
                    word_q  <= next_sticky;
                    write_q <= 1'b1;
                    pending <= poll;
                    cnt     <= CW'(HOLD_CYCLES - 1);
                    state   <= HOLD;
                end else begin
                    pending <= new_evt | poll;
                end
            end else begin
                write_q <= 1'b0;
                pending <= pending | new_evt | poll;
                // The strobe cycle is not a hold cycle; count only the quiet cycles after it,
                // so the next strobe is at least HOLD_CYCLES+2 clocks later.
                if (!write_q) begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_f2h_status_tx.sv
// tb_f2h_status_tx: directed stimulus with a queue scoreboard of expected strobe words and cycles.
module tb_f2h_status_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_done = 1'b0;
    logic        ldst_done = 1'b0;
    logic        cu_done = 1'b0;
    logic        fetch_done = 1'b0;
    logic [27:0] exec_done = '0;
    f2h_status_tx_if bus();
    f2h_status_tx #(.HOLD_CYCLES(16), .ACK_OPCODE(4'hF), .POLL_OPCODE(4'hE)) dut (
        .clk(clk), .rst_n(rst_n), .move_done(move_done), .ldst_done(ldst_done),
        .cu_done(cu_done), .fetch_done(fetch_done), .exec_done(exec_done), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct { logic [31:0] w; int c; } exp_t;
    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_s = -1000;
    int s;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic push(input logic [31:0] w, input int c);
        exp_t e;
        e.w = w;
        e.c = c;
        q.push_back(e);
    endtask
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_s = -1000;
        end else if (bus.f2h_write) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: word %h at cycle %0d, required no strobe", bus.f2h_pio32, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_word", bus.f2h_pio32, e.w);
                chk("strobe_cycle", 32'(cyc), 32'(e.c));
                chk("strobe_gap_ge_18", {31'b0, (cyc - last_s) >= 18}, 32'd1);
            end
            last_s = cyc;
        end else if (q.size() > 0 && cyc > q[0].c) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: none by cycle %0d, required word %h at cycle %0d", cyc, e.w, e.c);
        end
    end
    initial begin
        bus.h2f_pio32 = '0;
        bus.h2f_write = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pio", bus.f2h_pio32, 32'h0);
        chk("reset_write", {31'b0, bus.f2h_write}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // first event: two-clock latency, then a quiet hold window
        cu_done = 1'b1;
        s = cyc + 2;
        push(32'h2000_0000, s);
        // event during hold is deferred to the first idle cycle
        wait_until(s + 4);
        exec_done[0] = 1'b1;
        s = s + 18;
        push(32'h2000_0001, s);
        wait_until(s + 20);
        // ACK clears sticky without sending; a re-rise of cu reports alone
        bus.h2f_pio32 = 32'hF000_0000;
        bus.h2f_write = 1'b1;
        @(negedge clk);
        bus.h2f_write = 1'b0;
        cu_done = 1'b0;
        @(negedge clk);
        cu_done = 1'b1;
        s = cyc + 2;
        push(32'h2000_0000, s);
        wait_until(s + 20);
        // ACK and a new edge in the same cycle: the edge survives
        bus.h2f_pio32 = 32'hF123_4567;
        bus.h2f_write = 1'b1;
        move_done = 1'b1;
        s = cyc + 2;
        push(32'h8000_0000, s);
        @(negedge clk);
        bus.h2f_write = 1'b0;
        wait_until(s + 20);
        // POLL resends; two POLLs inside one hold window give exactly one extra strobe
        bus.h2f_pio32 = 32'hE000_0000;
        bus.h2f_write = 1'b1;
        s = cyc + 2;
        push(32'h8000_0000, s);
        @(negedge clk);
        bus.h2f_write = 1'b0;
        wait_until(s + 2);
        bus.h2f_pio32 = 32'hE0AB_CDEF;
        bus.h2f_write = 1'b1;
        @(negedge clk);
        bus.h2f_write = 1'b0;
        wait_until(s + 6);
        bus.h2f_pio32 = 32'hE000_0000;
        bus.h2f_write = 1'b1;
        @(negedge clk);
        bus.h2f_write = 1'b0;
        s = s + 18;
        push(32'h8000_0000, s);
        wait_until(s + 25);
        // re-rising an already sticky bit must stay silent; non-reserved opcodes are ignored
        move_done = 1'b0;
        bus.h2f_pio32 = 32'h1FFF_FFFF;
        bus.h2f_write = 1'b1;
        @(negedge clk);
        bus.h2f_write = 1'b0;
        move_done = 1'b1;
        repeat (22) @(negedge clk);
        // reset one cycle after a strobe, inputs high across release
        bus.h2f_pio32 = 32'hE000_0000;
        bus.h2f_write = 1'b1;
        s = cyc + 2;
        push(32'h8000_0000, s);
        @(negedge clk);
        bus.h2f_write = 1'b0;
        wait_until(s + 1);
        rst_n = 1'b0;
        ldst_done = 1'b1;
        cu_done = 1'b1;
        fetch_done = 1'b1;
        exec_done = 28'hABC_DEF1;
        #1;
        chk("midreset_pio", bus.f2h_pio32, 32'h0);
        chk("midreset_write", {31'b0, bus.f2h_write}, 32'h0);
        repeat (3) @(negedge clk);
        chk("held_reset_pio", bus.f2h_pio32, 32'h0);
        rst_n = 1'b1;
        s = cyc + 2;
        push(32'hFABC_DEF1, s);
        wait_until(s + 25);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
